msrv32_alu_arbiter: RTL and testbench

- Shares one msrv32_alu instance between two requesters: requester 0 is the execute path and requester 1 is the auxiliary/debug path.
- Each requester uses a valid/ready handshake for requests and a separate valid/ready handshake for responses.
- The block registers the operands, waits a configurable ALU latency, captures the result, and returns it only to the requester that issued the operation.
- It sits between the requesters and the ALU's op_1_in, op_2_in, opcode_in and result_out ports.

---
 rtl/msrv32_alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_msrv32_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_arbiter.sv
// msrv32_alu_arbiter: shares one msrv32_alu between the execute path (req0)
// and the auxiliary/debug path (req1). One operation is in flight at a time:
// the winner's operands are registered, held on the ALU inputs for ALU_LAT
// cycles, and the sampled result is returned only to the requester that
// issued the operation.
module msrv32_alu_arbiter #(
    parameter int PRIO_MODE = 0,   // 0 = round-robin, 1 = req0 always wins
    parameter int ALU_LAT   = 1    // EXEC cycles before alu_result_in is sampled (1..4)
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req0_valid_in,
    output logic        req0_ready_out,
    input  logic [3:0]  req0_opcode_in,
    input  logic [31:0] req0_op_1_in,
    input  logic [31:0] req0_op_2_in,
    output logic        rsp0_valid_out,
    input  logic        rsp0_ready_in,
    output logic [31:0] rsp0_result_out,
    input  logic        req1_valid_in,
    output logic        req1_ready_out,
    input  logic [3:0]  req1_opcode_in,
    input  logic [31:0] req1_op_1_in,
    input  logic [31:0] req1_op_2_in,
    output logic        rsp1_valid_out,
    input  logic        rsp1_ready_in,
    output logic [31:0] rsp1_result_out,
    output logic [3:0]  alu_opcode_out,
    output logic [31:0] alu_op_1_out,
    output logic [31:0] alu_op_2_out,
    input  logic [31:0] alu_result_in,
    output logic        busy_out,
    output logic        last_grant_out
);

    // An out-of-range latency cannot be represented by the 2-bit counter.
    if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
        $error("msrv32_alu_arbiter: ALU_LAT must be in the range 1..4");
    end

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        owner_reg;
    logic        last_grant_reg;
    logic [1:0]  cnt_reg;
    logic [3:0]  opcode_reg;
    logic [31:0] op_1_reg;
    logic [31:0] op_2_reg;
    logic [31:0] result_reg;

    logic [1:0]  req_valid_vec;
    logic [1:0]  req_ready_vec;
    logic [1:0]  rsp_valid_vec;
    logic [1:0]  rsp_ready_vec;
    logic        grant;
    logic        accept;
    logic        consume;

    assign req_valid_vec = {req1_valid_in, req0_valid_in};
    assign rsp_ready_vec = {rsp1_ready_in, rsp0_ready_in};

    // Pick the winner among the valid requesters; a tie goes to req0 in
    // fixed-priority mode, otherwise to whoever was not granted last.
    always_comb begin
        grant = 1'b0;
        if (req_valid_vec == 2'b11) begin
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant_reg;
        end else begin
            grant = req_valid_vec[1];
        end
    end

    // Requests are taken only in IDLE and never while reset is asserted.
    assign accept  = (state_reg == IDLE) && rst_in && (req_valid_vec != 2'b00);
    assign consume = (state_reg == RESP) && rsp_ready_vec[owner_reg];

    // Per-requester handshake outputs: ready only for the winner, response
    // valid only for the owner of the operation in flight.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_ready_vec[gi] = accept && (grant == 1'(gi));
        assign rsp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end

    // Next-state logic for IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt_reg == LAT_M1) state_next = RESP;
            RESP:    if (consume) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture on grant, latency count and result capture in EXEC.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= 2'd0;
            opcode_reg     <= 4'd0;
            op_1_reg       <= 32'd0;
            op_2_reg       <= 32'd0;
            result_reg     <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        owner_reg      <= grant;
                        last_grant_reg <= grant;
                        cnt_reg        <= 2'd0;
                        opcode_reg     <= grant ? req1_opcode_in : req0_opcode_in;
                        op_1_reg       <= grant ? req1_op_1_in   : req0_op_1_in;
                        op_2_reg       <= grant ? req1_op_2_in   : req0_op_2_in;
                    end
                end
                EXEC: begin
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == LAT_M1) begin
                        result_reg <= alu_result_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready_out  = req_ready_vec[0];
    assign req1_ready_out  = req_ready_vec[1];
    assign rsp0_valid_out  = rsp_valid_vec[0];
    assign rsp1_valid_out  = rsp_valid_vec[1];
    assign rsp0_result_out = result_reg;
    assign rsp1_result_out = result_reg;
    assign alu_opcode_out  = opcode_reg;
    assign alu_op_1_out    = op_1_reg;
    assign alu_op_2_out    = op_2_reg;
    assign busy_out        = (state_reg != IDLE);
    assign last_grant_out  = last_grant_reg;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench for msrv32_alu_arbiter: three configurations (round-robin/LAT1,
// fixed-priority/LAT1, round-robin/LAT3) run side by side, each with a
// transaction-level model, a per-cycle compare process, directed cases with
// literal expectations and a randomized phase.
module tb_msrv32_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    logic [3:0] opc_tbl [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    // Reference ALU (msrv32 opcode = {funct7[5], funct3}).
    function automatic logic [31:0] alu_f(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        case (o)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int cfg, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [cfg %0d]: got %h, expected %h", name, cfg, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int P = (gi == 1) ? 1 : 0;
        localparam int L = (gi == 2) ? 3 : 1;

        logic        rst = 1'b0;
        logic [1:0]  req_valid = 2'b00;
        logic [1:0]  rsp_ready = 2'b00;
        logic [1:0]  req_ready;
        logic [1:0]  rsp_valid;
        logic [3:0]  req_opc [2] = '{4'd0, 4'd0};
        logic [31:0] req_a [2] = '{32'd0, 32'd0};
        logic [31:0] req_b [2] = '{32'd0, 32'd0};
        logic [31:0] rsp_res [2];
        logic [3:0]  alu_opc;
        logic [31:0] alu_a, alu_b, alu_res;
        logic        busy, last_grant;
        int          k = 0;
        bit          done_i = 1'b0;
        req_t        q0[$];
        req_t        q1[$];

        // Transaction-level model state
        bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
        int          m_hs = 0, cyc = 0;
        logic [31:0] m_res = 32'd0, m_a = 32'd0, m_b = 32'd0;
        logic [3:0]  m_opc = 4'd0;
        logic [1:0]  fire = 2'b00, consume = 2'b00;

        msrv32_alu_arbiter #(.PRIO_MODE(P), .ALU_LAT(L)) dut (
            .clk_in(clk), .rst_in(rst),
            .req0_valid_in(req_valid[0]), .req0_ready_out(req_ready[0]),
            .req0_opcode_in(req_opc[0]), .req0_op_1_in(req_a[0]), .req0_op_2_in(req_b[0]),
            .rsp0_valid_out(rsp_valid[0]), .rsp0_ready_in(rsp_ready[0]),
            .rsp0_result_out(rsp_res[0]),
            .req1_valid_in(req_valid[1]), .req1_ready_out(req_ready[1]),
            .req1_opcode_in(req_opc[1]), .req1_op_1_in(req_a[1]), .req1_op_2_in(req_b[1]),
            .rsp1_valid_out(rsp_valid[1]), .rsp1_ready_in(rsp_ready[1]),
            .rsp1_result_out(rsp_res[1]),
            .alu_opcode_out(alu_opc), .alu_op_1_out(alu_a), .alu_op_2_out(alu_b),
            .alu_result_in(alu_res), .busy_out(busy), .last_grant_out(last_grant)
        );

        // ALU model: the result is only correct on the L-th cycle after the
        // handshake; every other cycle it is deliberately corrupted.
        always @(posedge clk) k <= (fire != 2'b00) ? 1 : k + 1;
        assign alu_res = (k == L) ? alu_f(alu_opc, alu_a, alu_b)
                                  : (alu_f(alu_opc, alu_a, alu_b) ^ 32'h5A5AA5A5);

        // Compare process: expected outputs from the model, every cycle.
        initial begin : cmp
            logic [1:0] er, ev;
            bit g;
            forever begin
                @(negedge clk);
                er = 2'b00;
                g  = 1'b0;
                if (rst && !m_busy && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) g = (P == 1) ? 1'b0 : !m_last;
                    else g = req_valid[1];
                    er[g] = 1'b1;
                end
                ev = 2'b00;
                if (m_busy && cyc >= m_hs + L + 1) ev[m_owner] = 1'b1;
                chk("req_ready", gi, 32'(req_ready), 32'(er));
                chk("rsp_valid", gi, 32'(rsp_valid), 32'(ev));
                chk("busy", gi, 32'(busy), 32'(m_busy));
                chk("last_grant", gi, 32'(last_grant), 32'(m_last));
                chk("alu_opcode", gi, 32'(alu_opc), 32'(m_opc));
                chk("alu_op_1", gi, alu_a, m_a);
                chk("alu_op_2", gi, alu_b, m_b);
                for (int n = 0; n < 2; n++)
                    if (ev[n]) chk("rsp_result", gi, rsp_res[n], m_res);
                fire    = er & req_valid;
                consume = ev & rsp_ready;
            end
        end

        // Model update at the clock edge.
        initial begin : mdl
            forever begin
                @(posedge clk);
                if (!rst) begin
                    m_busy = 1'b0; m_last = 1'b1; m_opc = 4'd0; m_a = 32'd0; m_b = 32'd0;
                end else if (fire != 2'b00) begin
                    m_owner = fire[1];
                    m_last  = fire[1];
                    m_hs    = cyc;
                    m_opc   = req_opc[fire[1]];
                    m_a     = req_a[fire[1]];
                    m_b     = req_b[fire[1]];
                    m_res   = alu_f(m_opc, m_a, m_b);
                    m_busy  = 1'b1;
                end else if (consume != 2'b00) begin
                    m_busy = 1'b0;
                end
                cyc++;
            end
        end

        // Requesters: present queued requests, hold them until accepted.
        initial begin : rqs
            req_t r;
            forever begin
                @(posedge clk);
                #1;
                if (fire[0]) req_valid[0] = 1'b0;
                if (fire[1]) req_valid[1] = 1'b0;
                if (!req_valid[0] && q0.size() > 0) begin
                    r = q0.pop_front();
                    req_opc[0] = r.opc; req_a[0] = r.a; req_b[0] = r.b; req_valid[0] = 1'b1;
                end
                if (!req_valid[1] && q1.size() > 0) begin
                    r = q1.pop_front();
                    req_opc[1] = r.opc; req_a[1] = r.a; req_b[1] = r.b; req_valid[1] = 1'b1;
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic push(input int n, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b);
            req_t r;
            r.opc = o; r.a = a; r.b = b;
            if (n == 0) q0.push_back(r);
            else q1.push_back(r);
        endtask

        task automatic do_reset();
            tick();
            rst = 1'b0;
            q0.delete(); q1.delete();
            req_valid = 2'b00; rsp_ready = 2'b00;
            tick();
            rst = 1'b1;
        endtask

        task automatic wait_rsp(input int n, input string name);
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (rsp_valid[n]) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL %s [cfg %0d]: rsp%0d_valid not seen within 40 cycles", name, gi, n);
            end
        endtask

        task automatic wait_any(output int n);
            n = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (rsp_valid[0]) begin n = 0; break; end
                if (rsp_valid[1]) begin n = 1; break; end
            end
        endtask

        // Directed cases followed by randomized traffic.
        initial begin : drv
            int n;
            repeat (2) tick();
            rst = 1'b1;

            // Single ADD on req0
            push(0, 4'b0000, 32'hAABBCCDD, 32'h11223344);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (req_valid[0]) break;
            end
            chk("add_ready0_first_cycle", gi, 32'(req_ready[0]), 32'd1);
            wait_rsp(0, "add_rsp");
            chk("add_result", gi, rsp_res[0], 32'hBBDE0021);
            chk("add_rsp1_quiet", gi, 32'(rsp_valid[1]), 32'd0);
            tick(); rsp_ready[0] = 1'b1;
            tick(); rsp_ready[0] = 1'b0;

            // Simultaneous XOR (req0) and AND (req1)
            do_reset();
            rsp_ready = 2'b11;
            push(0, 4'b0100, 32'hAABBCCDD, 32'h11223344);
            push(1, 4'b0111, 32'hAABBCCDD, 32'h11223344);
            wait_rsp(0, "xor_rsp");
            chk("xor_result", gi, rsp_res[0], 32'hBB99FF99);
            chk("xor_grant", gi, 32'(last_grant), 32'd0);
            wait_rsp(1, "and_rsp");
            chk("and_result", gi, rsp_res[1], 32'h00220044);
            chk("and_grant", gi, 32'(last_grant), 32'd1);

            // Both requesters continuously valid
            do_reset();
            rsp_ready = 2'b11;
            for (int i = 0; i < 4; i++) begin
                push(0, 4'b0000, $urandom, $urandom);
                push(1, 4'b1000, $urandom, $urandom);
            end
            for (int i = 0; i < 8; i++) begin
                wait_any(n);
                if (i < 4) chk("grant_order", gi, 32'(n), (P == 1) ? 32'd0 : 32'(i % 2));
            end

            // Response backpressure on req1 OR
            do_reset();
            push(1, 4'b0110, 32'hAABBCCDD, 32'h11223344);
            wait_rsp(1, "or_rsp");
            push(0, 4'b0000, 32'd1, 32'd2);
            for (int i = 0; i < 5; i++) begin
                chk("bp_rsp1_valid", gi, 32'(rsp_valid[1]), 32'd1);
                chk("bp_result", gi, rsp_res[1], 32'hBBBBFFDD);
                chk("bp_busy", gi, 32'(busy), 32'd1);
                chk("bp_ready0", gi, 32'(req_ready[0]), 32'd0);
                @(negedge clk);
            end
            tick(); rsp_ready = 2'b11;
            wait_rsp(0, "bp_next_rsp");
            chk("bp_next_result", gi, rsp_res[0], 32'd3);

            // Reset during EXEC
            do_reset();
            rsp_ready = 2'b11;
            push(0, 4'b0000, 32'd5, 32'd7);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (req_valid[0] && req_ready[0]) break;
            end
            tick(); rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_exec_busy", gi, 32'(busy), 32'd0);
            chk("rst_exec_rsp_valid", gi, 32'(rsp_valid), 32'd0);
            chk("rst_exec_last_grant", gi, 32'(last_grant), 32'd1);
            tick(); rst = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("rst_exec_no_stale", gi, 32'(rsp_valid), 32'd0);
            end

            // Reset during RESP
            tick(); rsp_ready = 2'b00;
            push(1, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00);
            wait_rsp(1, "rst_resp_rsp");
            tick(); rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_resp_busy", gi, 32'(busy), 32'd0);
            chk("rst_resp_rsp_valid", gi, 32'(rsp_valid), 32'd0);
            chk("rst_resp_last_grant", gi, 32'(last_grant), 32'd1);
            tick(); rst = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("rst_resp_no_stale", gi, 32'(rsp_valid), 32'd0);
            end

            // A request after reset completes normally
            tick(); rsp_ready = 2'b11;
            push(0, 4'b1000, 32'h10, 32'h3);
            wait_rsp(0, "post_rst_rsp");
            chk("post_rst_result", gi, rsp_res[0], 32'h0000000D);

            // Randomized traffic with random backpressure and rare resets
            for (int c = 0; c < 1500; c++) begin
                tick();
                rsp_ready = 2'($urandom);
                if (q0.size() < 2 && $urandom_range(0, 3) == 0)
                    push(0, opc_tbl[$urandom_range(0, 9)], $urandom, $urandom);
                if (q1.size() < 2 && $urandom_range(0, 3) == 0)
                    push(1, opc_tbl[$urandom_range(0, 9)], $urandom, $urandom);
                if ($urandom_range(0, 299) == 0) begin
                    rst = 1'b0;
                    q0.delete(); q1.delete();
                    req_valid = 2'b00;
                end else begin
                    rst = 1'b1;
                end
            end
            rsp_ready = 2'b11;
            repeat (60) tick();
            done_i = 1'b1;
        end
    end

    // Wait for all configurations, then report.
    initial begin
        for (int t = 0; t < 90000; t++) begin
            @(posedge clk);
            if (g_cfg[0].done_i && g_cfg[1].done_i && g_cfg[2].done_i) break;
        end
        if (!(g_cfg[0].done_i && g_cfg[1].done_i && g_cfg[2].done_i)) begin
            vectors++; miscompares++;
            $display("FAIL watchdog: run did not complete within 90000 cycles");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
